// File: rtl/gpu_prog_responder_if.sv
// Prefetcher, local RAM and external bus signals of the GPU program-fetch responder.
// The slave modport is the responder's view; master is the surrounding system.
interface gpu_prog_responder_if #(
  parameter int unsigned LOCAL_AW = 10
);
  logic                progreq;
  logic [21:0]         progaddr;
  logic                pabort;
  logic                progack;
  logic [31:0]         gpu_data;
  logic                ram_cs;
  logic [LOCAL_AW-1:0] ram_addr;
  logic [31:0]         ram_dout;
  logic                ext_req;
  logic [21:0]         ext_addr;
  logic                ext_ack;
  logic [31:0]         ext_data;
  logic                busy;
  logic                timeout_err;

  modport slave (
    input  progreq, progaddr, pabort, ram_dout, ext_ack, ext_data,
    output progack, gpu_data, ram_cs, ram_addr, ext_req, ext_addr, busy, timeout_err
  );

  modport master (
    output progreq, progaddr, pabort, ram_dout, ext_ack, ext_data,
    input  progack, gpu_data, ram_cs, ram_addr, ext_req, ext_addr, busy, timeout_err
  );
endinterface

// File: rtl/gpu_prog_responder.sv
// GPU program-fetch responder: serves prefetcher longword fetches from local RAM
// or through a held-request external bus handshake with abort and timeout.
module gpu_prog_responder #(
  parameter logic [21:0]  LOCAL_BASE  = 22'h3C0C00,
  parameter int unsigned  LOCAL_AW    = 10,
  parameter int unsigned  EXT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  gpu_prog_responder_if.slave   bus
);

  localparam int unsigned   CW       = $clog2(EXT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(EXT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAM_RD  = 3'd1,
    RAM_CAP = 3'd2,
    EXT     = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ext_req_q, ext_req_d;
  logic [21:0]   ext_addr_q, ext_addr_d;
  logic [31:0]   gpu_data_q, gpu_data_d;
  logic          progack_q, progack_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          ram_cs_c;
  logic          local_hit_c;
  logic          abort_now_c;

  assign local_hit_c = (bus.progaddr[21:LOCAL_AW] == LOCAL_BASE[21:LOCAL_AW]);
  assign abort_now_c = abort_q | bus.pabort;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    cnt_d      = cnt_q;
    ext_req_d  = ext_req_q;
    ext_addr_d = ext_addr_q;
    gpu_data_d = gpu_data_q;
    progack_d  = 1'b0;
    timeout_d  = 1'b0;
    ram_cs_c   = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        cnt_d   = '0;
        if (!reset && bus.progreq && !bus.pabort) begin
          if (local_hit_c) begin
            ram_cs_c = 1'b1;
            state_d  = RAM_RD;
          end else begin
            ext_addr_d = bus.progaddr;
            ext_req_d  = 1'b1;
            state_d    = EXT;
          end
        end
      end

      RAM_RD: begin
        if (bus.pabort) begin
          state_d = IDLE;
        end else begin
          gpu_data_d = bus.ram_dout;
          progack_d  = 1'b1;
          state_d    = RAM_CAP;
        end
      end

      RAM_CAP: state_d = ACK;

      EXT: begin
        abort_d = abort_now_c;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (bus.ext_ack) begin
          ext_req_d = 1'b0;
          if (abort_now_c) begin
            state_d = IDLE;
          end else begin
            gpu_data_d = bus.ext_data;
            progack_d  = 1'b1;
            state_d    = RAM_CAP;
          end
        end else if (cnt_q >= CNT_LAST) begin
          // No response in time: deliver a NOP-fill word unless the fetch was cancelled
          ext_req_d = 1'b0;
          timeout_d = 1'b1;
          if (abort_now_c) begin
            state_d = IDLE;
          end else begin
            gpu_data_d = 32'hFFFF_FFFF;
            progack_d  = 1'b1;
            state_d    = RAM_CAP;
          end
        end
      end

      ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
      ext_req_q  <= 1'b0;
      ext_addr_q <= '0;
      gpu_data_q <= '0;
      progack_q  <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      abort_q    <= abort_d;
      cnt_q      <= cnt_d;
      ext_req_q  <= ext_req_d;
      ext_addr_q <= ext_addr_d;
      gpu_data_q <= gpu_data_d;
      progack_q  <= progack_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ram_cs      = ram_cs_c;
  assign bus.ram_addr    = ram_cs_c ? bus.progaddr[LOCAL_AW-1:0] : '0;
  assign bus.progack     = progack_q;
  assign bus.gpu_data    = gpu_data_q;
  assign bus.ext_req     = ext_req_q;
  assign bus.ext_addr    = ext_addr_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule
